coax_buffered_tx: RTL
=====================

Name: coax_buffered_tx

Overview:
- Buffered 3270 coax transmitter, parametrised in bit timing, FIFO depth and pre-emphasis delay.
- Host logic loads 10-bit words into an internal FIFO. A start strobe then commits them as one frame.
- The frame is serialised as bi-phase (Manchester) cells: line quiesce, start code violation, per-word sync/data/parity, then an end sequence.
- Sits between control and the tx_active/tx_inverted/tx_delay pads; tx is also exposed for RX loopback.

Parameters:
- CLOCKS_PER_BIT, 16, clocks per bit cell; must be even, >= 4.
- DEPTH, 256, FIFO depth in words; power of two, >= 2.
- DELAY_CLOCKS, 4, tx_delay lag behind tx in clocks; 1..CLOCKS_PER_BIT/2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data  input  10  word to load.
- load_strobe  input  1  push data into FIFO.
- start_strobe  input  1  begin frame transmission.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; load_strobe while full.
- active  output  1  frame in progress.
- tx  output  1  serial line level.
- tx_inverted  output  1  ~tx while active, else 0.
- tx_delay  output  1  tx delayed DELAY_CLOCKS clocks.

Behaviour:
- Reset, applied on any clock including mid-frame:
  - FIFO flushed, state IDLE.
  - active, tx, tx_inverted, tx_delay, overflow, full all 0; empty=1; level=0.
  - The tx_delay shift register is cleared.
- Cell encoding, CPB = CLOCKS_PER_BIT, H = CPB/2:
  - Bit 1: tx=0 for H clocks, then 1 for H clocks.
  - Bit 0: tx=1 for H clocks, then 0 for H clocks.
- FIFO:
  - load_strobe with full=0 writes data; level +1 next cycle.
  - load_strobe with full=1: data dropped, overflow set (sticky until reset).
  - A pop and a load in the same cycle leave level unchanged.
- States and transitions:
  - IDLE:
    - tx=0, active=0.
    - start_strobe with empty=0 → QUIESCE. active=1 and the first cell starts on the next cycle (latency 1).
    - start_strobe with empty=1 is ignored.
    - start_strobe while active is ignored.
  - QUIESCE: five bit-1 cells.
  - START_CV: tx=1 for CPB+H clocks, then tx=0 for CPB+H clocks.
  - WORD:
    - On the first clock of the sync cell, pop the FIFO head.
    - Send a sync bit-1 cell, then data[9] down to data[0], then the parity cell.
    - The parity bit makes the count of ones over data plus parity even.
  - On the last clock of the parity cell:
    - empty=0 → next WORD. Words loaded mid-frame extend the frame.
    - empty=1 → END.
  - END:
    - One bit-0 cell, then tx=1 for CPB+H clocks.
    - Then IDLE; active falls in the same cycle tx returns to 0.
- Frame length for N words: (5 + 3 + 12N + 1 + 1.5) × CPB clocks.
- All outputs are registered. tx_delay is a DELAY_CLOCKS-deep shift of tx and drains to 0 after the frame.
- A word loaded on the parity cell's last clock is counted as present and continues the frame.

Test Plan:
- Reset: then start_strobe with empty FIFO → active stays 0 and tx stays 0 for 100 clocks.
- Load 0x3FF, start, CPB=16:
  - Quiesce: 5 × (8 low, 8 high).
  - Code violation: 24 high, 24 low.
  - Sync cell 1, ten 1-cells, parity cell 0, end 0-cell, 24 high.
  - active high for exactly 360 clocks.
- Load 0x001 and 0x200 back-to-back, start:
  - First word: 9 zero cells then 1, parity 1.
  - Second word: 1 then 9 zeros, parity 1.
  - active lasts 552 clocks.
- Load 1 word, start, then load 0x155 during the first word's data cells:
  - Frame carries both words with no end sequence between them.
  - empty=1 after the second pop.
- Fill DEPTH words, then one more load_strobe:
  - full=1, level=DEPTH, overflow=1.
  - The extra word is never transmitted.
- Assert reset mid-data-cell → next cycle tx=0, active=0, level=0, and tx_delay=0 within DELAY_CLOCKS.

Source files
------------

// File: rtl/coax_buffered_tx.sv
// ============================================================================
// coax_buffered_tx
// ----------------------------------------------------------------------------
// Buffered IBM 3270 coax transmitter. The host pushes 10-bit words into an
// internal FIFO and then pulses a start strobe. Every word waiting in the FIFO
// goes out as one frame of bi-phase (Manchester) cells, in this order:
//   - line quiesce: five bit-1 cells
//   - start code violation: high for 1.5 cells, then low for 1.5 cells
//   - per word: a sync bit-1 cell, data[9] down to data[0], then an even
//     parity cell
//   - end sequence: one bit-0 cell, then high for 1.5 cells
// Words loaded while a frame is running make that frame longer, as long as
// they arrive by the last clock of the current word's parity cell.
//
// Cell encoding (H = CLOCKS_PER_BIT/2):
//   bit 1 -> low for H clocks, then high for H clocks
//   bit 0 -> high for H clocks, then low for H clocks
//
// Parameters:
//   CLOCKS_PER_BIT  clocks per bit cell (even, >= 4)
//   DEPTH           FIFO depth in words (power of two, >= 2)
//   DELAY_CLOCKS    lag of o_tx_delay behind o_tx (1 .. CLOCKS_PER_BIT/2)
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_data          word to load into the FIFO
//   i_load_strobe   push i_data into the FIFO (dropped when full)
//   i_start_strobe  start a frame (ignored when the FIFO is empty or a frame
//                   is already running)
//   o_full          FIFO holds DEPTH words
//   o_empty         FIFO holds no words
//   o_level         FIFO occupancy
//   o_overflow      sticky flag: a load was attempted while full
//   o_active        a frame is in progress
//   o_tx            serial line level (also used for RX loopback)
//   o_tx_inverted   ~o_tx while a frame is active, otherwise 0
//   o_tx_delay      o_tx delayed by DELAY_CLOCKS clocks (pre-emphasis pad)
// ============================================================================
module coax_buffered_tx #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int DEPTH          = 256,
    parameter int DELAY_CLOCKS   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [9:0]              i_data,
    input  logic                    i_load_strobe,
    input  logic                    i_start_strobe,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow,
    output logic                    o_active,
    output logic                    o_tx,
    output logic                    o_tx_inverted,
    output logic                    o_tx_delay
);

    // The whole frame is built from half cells of HALF clocks each, so
    // the sequencer only counts clocks within a half cell (r_tick) and half
    // cells within the current state (r_half).
    localparam int HALF   = CLOCKS_PER_BIT / 2;
    localparam int TICK_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

    // Index of the last half cell in each state.
    // Quiesce: 5 cells = 10 halves. Code violation: 3 high + 3 low halves.
    // Word: sync + 10 data + parity = 12 cells = 24 halves.
    // End: bit-0 cell (2 halves) + 3 high halves.
    localparam logic [4:0] QUIESCE_LAST = 5'd9;
    localparam logic [4:0] CV_LAST      = 5'd5;
    localparam logic [4:0] WORD_LAST    = 5'd23;
    localparam logic [4:0] END_LAST     = 5'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_START_CV,
        S_WORD,
        S_END
    } txState_t;

    // ------------------------------------------------------------------
    // Register and wire declarations
    // ------------------------------------------------------------------
    txState_t            r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [4:0]          r_half;

    logic [9:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [LVL_W-1:0]    r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;

    logic [9:0]          r_word;
    logic                r_parity;

    logic                r_tx;
    logic                r_active;
    logic                r_txInv;
    logic [DELAY_CLOCKS-1:0] r_delay;

    txState_t            w_stateNext;
    logic [TICK_W-1:0]   w_tickNext;
    logic [4:0]          w_halfNext;
    logic [4:0]          w_halfLast;
    logic                w_halfEnd;

    logic                w_push;
    logic                w_pop;
    logic [LVL_W-1:0]    w_countNext;

    logic [11:0]         w_cellBits;
    logic [3:0]          w_cellIdx;
    logic                w_cellBit;
    logic                w_txNext;
    logic                w_activeNext;
    logic                w_txInvNext;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // A load only lands when there is room. The head word is popped on
    // the very first clock of each word's sync cell; the sync cell itself
    // is a constant 1, so the popped word is in r_word well before its
    // first data cell is needed.
    assign w_push = i_load_strobe && !r_full;
    assign w_pop  = (r_state == S_WORD) && (r_half == 5'd0) &&
                    (r_tick == '0) && !r_empty;

    // The occupancy is tracked as a counter; a simultaneous push and pop
    // leaves it unchanged.
    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    // The word storage itself is plain memory without reset; only the
    // pointers and counter need to be flushed to empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and the flags derived from it. The flags are
    // registered from the next-count value so they line up exactly with
    // o_level. Overflow stays set until reset once a load hits a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count    <= w_countNext;
            r_full     <= (w_countNext == LVL_FULL);
            r_empty    <= (w_countNext == '0);
            r_overflow <= r_overflow | (i_load_strobe & r_full);
        end
    end

    // Capture the popped word together with its even-parity bit, so the
    // parity cell can be sent straight from a register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word   <= '0;
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_word   <= r_mem[r_rdPtr];
            r_parity <= ^r_mem[r_rdPtr];
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer: state register
    // ------------------------------------------------------------------
    // Holds the state plus the position inside it. The outputs below are
    // registered from the next-state values, so the registered state always
    // describes the cell that o_tx is showing in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_half  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_tick  <= w_tickNext;
            r_half  <= w_halfNext;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer: next-state logic
    // ------------------------------------------------------------------
    // Idle waits for a start strobe with words available. In every other
    // state the tick counter runs through a half cell, the half counter
    // runs through the state, and the last clock of the last half decides
    // where to go next. At the end of a word, a load arriving in that same
    // clock counts as a waiting word, so the frame carries on without an
    // end sequence in between.
    assign w_halfEnd = (r_tick == TICK_LAST);

    always_comb begin
        w_stateNext = r_state;
        w_tickNext  = r_tick;
        w_halfNext  = r_half;
        w_halfLast  = END_LAST;

        case (r_state)
            S_QUIESCE:  w_halfLast = QUIESCE_LAST;
            S_START_CV: w_halfLast = CV_LAST;
            S_WORD:     w_halfLast = WORD_LAST;
            default:    w_halfLast = END_LAST;
        endcase

        if (r_state == S_IDLE) begin
            w_tickNext = '0;
            w_halfNext = '0;
            if (i_start_strobe && !r_empty) begin
                w_stateNext = S_QUIESCE;
            end
        end else if (!w_halfEnd) begin
            w_tickNext = r_tick + 1'b1;
        end else begin
            w_tickNext = '0;
            if (r_half == w_halfLast) begin
                w_halfNext = '0;
                case (r_state)
                    S_QUIESCE:  w_stateNext = S_START_CV;
                    S_START_CV: w_stateNext = S_WORD;
                    S_WORD:     w_stateNext = (!r_empty || i_load_strobe) ?
                                              S_WORD : S_END;
                    default:    w_stateNext = S_IDLE;
                endcase
            end else begin
                w_halfNext = r_half + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer: output logic
    // ------------------------------------------------------------------
    // Works out the line level for the next clock. Inside a word, cell n
    // (0 = sync, 1..10 = data[9]..data[0], 11 = parity) takes its value
    // from bit 11-n of {1, word, parity}; the first half of a cell is the
    // complement of its value and the second half is the value itself.
    always_comb begin
        w_cellBits = {1'b1, r_word, r_parity};
        w_cellIdx  = 4'd11 - w_halfNext[4:1];
        w_cellBit  = w_cellBits[w_cellIdx];
        w_txNext   = 1'b0;

        case (w_stateNext)
            S_QUIESCE:  w_txNext = w_halfNext[0];
            S_START_CV: w_txNext = (w_halfNext < 5'd3);
            S_WORD:     w_txNext = w_halfNext[0] ? w_cellBit : ~w_cellBit;
            S_END:      w_txNext = (w_halfNext != 5'd1);
            default:    w_txNext = 1'b0;
        endcase

        w_activeNext = (w_stateNext != S_IDLE);
        w_txInvNext  = w_activeNext & ~w_txNext;
    end

    // Output registers. The delay line is a plain shift of the registered
    // line level, so it replays the frame DELAY_CLOCKS later and then drains
    // to 0 by itself once the line goes idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx     <= 1'b0;
            r_active <= 1'b0;
            r_txInv  <= 1'b0;
            r_delay  <= '0;
        end else begin
            r_tx       <= w_txNext;
            r_active   <= w_activeNext;
            r_txInv    <= w_txInvNext;
            r_delay[0] <= r_tx;
            for (int i = 1; i < DELAY_CLOCKS; i++) begin
                r_delay[i] <= r_delay[i-1];
            end
        end
    end

    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_level       = r_count;
    assign o_overflow    = r_overflow;
    assign o_active      = r_active;
    assign o_tx          = r_tx;
    assign o_tx_inverted = r_txInv;
    assign o_tx_delay    = r_delay[DELAY_CLOCKS-1];

endmodule
